// File: rtl/sample_delay_pkg.sv
// sample_delay_pkg
//   Shared widths and sample/address types for the sample delay line.
//   The sine generator's counter and ROM reuse these when their widths match.
//   Contents:
//     ADDRESS_WIDTH : log2 of delay buffer depth (maximum delay 2^ADDRESS_WIDTH-1)
//     DATA_WIDTH    : unsigned offset-binary sample width
//     addr_t        : buffer address type
//     sample_t      : sample type
package sample_delay_pkg;

  localparam int ADDRESS_WIDTH = 9;
  localparam int DATA_WIDTH    = 8;

  typedef logic [ADDRESS_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0]    sample_t;

endpackage

// File: rtl/sample_delay_ram.sv
// delay_ram
//   Circular sample store for sample_delay: one write port and one synchronous
//   read port on a single clock. A read and a write to the same address in the
//   same cycle return the old contents (read-before-write). Storage has no reset.
//   Ports:
//     clk   : clock
//     wen   : write enable
//     waddr : write address
//     wdata : write data
//     ren   : read enable; rdata holds its value while low
//     raddr : read address
//     rdata : registered read data, valid the cycle after ren
module delay_ram
  import sample_delay_pkg::*;
#(
  parameter int ADDR_W = ADDRESS_WIDTH,
  parameter int DATA_W = DATA_WIDTH
) (
  input  logic              clk,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ren,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wen) begin
      mem[waddr] <= wdata;
    end
    if (ren) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sample_delay.sv
// sample_delay
//   Programmable delay line for a strobed stream of unsigned samples. Each
//   strobe writes din into a circular buffer and returns the sample written
//   `offset` strobes earlier, one cycle after the strobe. A fill counter masks
//   locations not yet written since reset; offset 0 forwards din directly.
//   Optional feature macro: SAMPLE_DELAY_MIX_EN adds the `mix` echo output,
//   the average of din and the delayed sample (din alone on invalid strobes).
//   Ports:
//     clk        : system clock, rising edge
//     rst        : asynchronous active-high reset
//     en         : sample strobe
//     din        : input sample
//     offset     : delay in strobes, sampled on each strobe
//     dout       : delayed sample, holds between valid strobes
//     dout_valid : one-cycle pulse per valid strobe
//     mix        : echo output (SAMPLE_DELAY_MIX_EN only)
module sample_delay
  import sample_delay_pkg::*;
#(
  parameter int ADDR_W = ADDRESS_WIDTH,
  parameter int DATA_W = DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] offset,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid
`ifdef SAMPLE_DELAY_MIX_EN
  ,
  output logic [DATA_W-1:0] mix
`endif
);

  localparam logic [ADDR_W:0] FILL_MAX = {1'b1, {ADDR_W{1'b0}}};

  // Stage p0: pointer, fill count and per-strobe decisions
  logic [ADDR_W-1:0] wr_ptr_p0;
  logic [ADDR_W:0]   fill_p0;
  logic [ADDR_W-1:0] rd_addr_p0;
  logic              vld_p0;
  logic              fwd_p0;

  assign rd_addr_p0 = wr_ptr_p0 - offset;
  assign vld_p0     = en && ({1'b0, offset} <= fill_p0);
  assign fwd_p0     = (offset == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_p0 <= '0;
      fill_p0   <= '0;
    end else if (en) begin
      wr_ptr_p0 <= wr_ptr_p0 + 1'b1;
      if (fill_p0 != FILL_MAX) begin
        fill_p0 <= fill_p0 + 1'b1;
      end
    end
  end

  // Stage p1: RAM read data, forwarded sample and output selection
  logic [DATA_W-1:0] ram_q_p1;
  logic [DATA_W-1:0] fwd_data_p1;
  logic              fwd_p1;
  logic              vld_p1;

  delay_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .wen   (en),
    .waddr (wr_ptr_p0),
    .wdata (din),
    .ren   (vld_p0 && !fwd_p0),
    .raddr (rd_addr_p0),
    .rdata (ram_q_p1)
  );

  // dout is a mux of registers that only change on valid strobes, so it holds
  // across idle and invalid strobes. Reset selects the zeroed forward register,
  // which keeps the unreset RAM output off dout until the first valid read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      fwd_p1      <= 1'b1;
      fwd_data_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        fwd_p1 <= fwd_p0;
        if (fwd_p0) begin
          fwd_data_p1 <= din;
        end
      end
    end
  end

  assign dout       = fwd_p1 ? fwd_data_p1 : ram_q_p1;
  assign dout_valid = vld_p1;

`ifdef SAMPLE_DELAY_MIX_EN
  function automatic logic [DATA_W-1:0] mix_avg(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[DATA_W:1];
  endfunction

  logic [DATA_W-1:0] mix_din_p1;
  logic              mix_avg_p1;

  // With offset 0 the delayed sample equals din, so the average reduces to din
  // and shares the pass-through path with invalid strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mix_din_p1 <= '0;
      mix_avg_p1 <= 1'b0;
    end else if (en) begin
      mix_din_p1 <= din;
      mix_avg_p1 <= vld_p0 && !fwd_p0;
    end
  end

  assign mix = mix_avg_p1 ? mix_avg(mix_din_p1, ram_q_p1) : mix_din_p1;
`endif

endmodule

// File: tb/tb_sample_delay.sv
// tb_sample_delay
//   Self-checking bench for sample_delay. A reference model keeps the full list
//   of samples written since reset; each strobe looks back `offset` entries in
//   that list. Directed scenarios from the design notes plus a random phase.
//   Mix checks are compiled when SAMPLE_DELAY_MIX_EN is defined.
module tb_sample_delay;
  import sample_delay_pkg::*;

  logic    clk = 1'b0;
  logic    rst;
  logic    en;
  sample_t din;
  addr_t   offset;
  sample_t dout;
  logic    dout_valid;
`ifdef SAMPLE_DELAY_MIX_EN
  sample_t mix;
  int      exp_mix;
`endif

  int checks = 0;
  int errors = 0;

  int      hist[$];
  int      exp_dout;
  logic    exp_valid;

  sample_delay dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .din        (din),
    .offset     (offset),
    .dout       (dout),
    .dout_valid (dout_valid)
`ifdef SAMPLE_DELAY_MIX_EN
    ,
    .mix        (mix)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, "_dout"}, int'(dout), exp_dout);
    check_val({tag, "_valid"}, int'(dout_valid), int'(exp_valid));
`ifdef SAMPLE_DELAY_MIX_EN
    check_val({tag, "_mix"}, int'(mix), exp_mix);
`endif
  endtask

  // Model step taken at the clock edge using the inputs being presented.
  task automatic model_edge(input logic e, input int d, input int o);
    int delayed;
    exp_valid = 1'b0;
    if (e) begin
      if (o <= hist.size()) begin
        delayed   = (o == 0) ? d : hist[hist.size() - o];
        exp_dout  = delayed;
        exp_valid = 1'b1;
`ifdef SAMPLE_DELAY_MIX_EN
        exp_mix   = (d + delayed) / 2;
`endif
      end else begin
`ifdef SAMPLE_DELAY_MIX_EN
        exp_mix = d;
`endif
      end
      hist.push_back(d);
    end
  endtask

  // One clock cycle: inputs driven one time unit after the previous edge,
  // outputs sampled one time unit after this edge.
  task automatic cycle(input logic e, input int d, input int o, input string tag);
    en     = e;
    din    = sample_t'(d);
    offset = addr_t'(o);
    @(posedge clk);
    model_edge(e, d, o);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    en  = 1'b0;
    hist.delete();
    exp_dout  = 0;
    exp_valid = 1'b0;
`ifdef SAMPLE_DELAY_MIX_EN
    exp_mix   = 0;
`endif
    #2;
    check_outputs({tag, "_async"});
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs({tag, "_held"});
  endtask

  initial begin
    int d;
    rst    = 1'b1;
    en     = 1'b0;
    din    = '0;
    offset = '0;
    exp_dout  = 0;
    exp_valid = 1'b0;
`ifdef SAMPLE_DELAY_MIX_EN
    exp_mix   = 0;
`endif
    #3;
    check_outputs("por");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill then delay: offset 4, din 1..10
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b1, k, 4, "fill");
      check_val("fill_const_valid", int'(dout_valid), (k >= 5) ? 1 : 0);
      if (k >= 5) check_val("fill_const_dout", int'(dout), k - 4);
    end
    cycle(1'b0, 0, 4, "fill_idle");

    // Zero offset forwards din, valid from the first strobe
    do_reset("rst_zero");
    cycle(1'b1, 7, 0, "zero");
    check_val("zero_first", int'(dout), 7);
    cycle(1'b1, 9, 0, "zero");
    cycle(1'b1, 11, 0, "zero");
    check_val("zero_last", int'(dout), 11);
    cycle(1'b0, 0, 0, "zero_idle");

    // Wrap-around at maximum delay
    do_reset("rst_wrap");
    for (int k = 0; k < 1200; k++) begin
      cycle(1'b1, k % 256, 511, "wrap");
      if (k == 511) check_val("wrap_first", int'(dout), 0);
      if (k > 511 && (k % 97 == 0)) check_val("wrap_const", int'(dout), (k - 511) % 256);
    end

    // Sparse strobes: en every third cycle
    do_reset("rst_sparse");
    for (int k = 0; k < 45; k++) begin
      cycle((k % 3) == 0, int'($urandom_range(0, 255)), 2, "sparse");
    end

    // Mid-stream reset
    do_reset("rst_mid_pre");
    for (int k = 0; k < 20; k++) cycle(1'b1, int'($urandom_range(0, 255)), 3, "mid_pre");
    do_reset("rst_mid");
    cycle(1'b1, 33, 3, "mid_post");
    cycle(1'b1, 44, 3, "mid_post");
    cycle(1'b1, 55, 3, "mid_post");
    check_val("mid_inv3", int'(dout_valid), 0);
    cycle(1'b1, 66, 3, "mid_post");
    check_val("mid_first", int'(dout), 33);
    check_val("mid_first_valid", int'(dout_valid), 1);

    // Random en, din and offset changes
    do_reset("rst_rand");
    for (int k = 0; k < 3000; k++) begin
      int o;
      if (k % 400 == 0) o = int'($urandom_range(0, 511));
      else              o = int'($urandom_range(0, 12));
      d = int'($urandom_range(0, 255));
      cycle($urandom_range(0, 3) != 0, d, o, "rand");
    end

`ifdef SAMPLE_DELAY_MIX_EN
    // Mix directed values
    do_reset("rst_mix");
    cycle(1'b1, 100, 1, "mix");
    check_val("mix_inv", int'(mix), 100);
    cycle(1'b1, 200, 1, "mix");
    check_val("mix_avg", int'(mix), 150);
    cycle(1'b1, 255, 1, "mix");
    cycle(1'b1, 255, 1, "mix");
    check_val("mix_top", int'(mix), 255);
    cycle(1'b0, 0, 1, "mix_idle");
    check_val("mix_hold", int'(mix), 255);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
